hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the pipelined RV32 core. It generalises the fixed EX/MEM/WB bypass and load-use stall logic to a configurable number of post-decode stages and a configurable load latency. It sits beside the ID stage and tracks in-flight register writes in a shifting slot array. Each cycle it produces a stall request and the forwarded rs1/rs2 operands.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width (2**AW architectural registers; x0 is hardwired zero)
DEPTH, 3, number of post-ID stages that hold a result before it is written to the regfile (slot 0 = EX, slot DEPTH-1 = WB); legal range 2..8
LOAD_LAT, 1, first slot index at which load data is valid; must satisfy 1 <= LOAD_LAT <= DEPTH-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  ID holds a real instruction this cycle
issue_rd  in  AW  destination register of the ID instruction
issue_wen  in  1  ID instruction writes the regfile
issue_is_load  in  1  ID instruction result comes from data memory
flush  in  1  branch/jump taken in EX; the ID instruction is killed
src1_addr  in  AW  rs1 address of the ID instruction
src2_addr  in  AW  rs2 address of the ID instruction
rf_rs1_data  in  XLEN  regfile read data for src1
rf_rs2_data  in  XLEN  regfile read data for src2
stage_data  in  DEPTH*XLEN  result value of slot k on bits [k*XLEN +: XLEN]
stall  out  1  hold IF/ID, insert a bubble into EX
fwd_rs1_data  out  XLEN  forwarded rs1 operand
fwd_rs2_data  out  XLEN  forwarded rs2 operand
fwd1_sel  out  4  0 = regfile; k+1 = forwarded from slot k
fwd2_sel  out  4  same encoding for rs2
pending_cnt  out  4  registered count of valid slots

Behaviour:
- Slot fields: v, rd[AW], avail (0 for non-load, LOAD_LAT for load).
- Reset (async): all v = 0 and pending_cnt = 0. In reset: stall = 0, fwd*_sel = 0, fwd_rs*_data = rf_rs*_data.
- Every posedge, slots shift: slot[k+1] <= slot[k] for k = 0..DEPTH-2. The slot[DEPTH-1] contents retire.
- slot[0] loads the issue fields only when issue_valid & issue_wen & (issue_rd != 0) & !stall & !flush. Otherwise slot[0] becomes a bubble (v = 0).
- Priority: flush beats stall. A flushed instruction never stalls, so stall is forced to 0 while flush = 1.
- Lookup (combinational, per source):
  - A source with addr 0 or !issue_valid gives sel = 0 and data = rf data.
  - Otherwise the match is the lowest k with v & rd == addr (youngest writer wins).
  - If the match has k >= avail: sel = k+1 and data = stage_data slot k.
  - If the match has k < avail, the source is not ready.
  - No match: sel = 0, data = rf data.
- stall = (src1 not ready | src2 not ready) & !flush.
- Load-use latency: with LOAD_LAT = 1, a dependent instruction directly behind a load stalls exactly 1 cycle. In general it stalls LOAD_LAT cycles.
- Slot DEPTH-1 is forwarded even though the regfile writes it the same edge, which covers write/read in the same cycle.
- pending_cnt = number of v bits after the edge, range 0..DEPTH.
- A stall while slots are draining still shifts the older slots. Stall only affects slot[0] insertion.
- reset asserted mid-operation clears every slot immediately. Results that were in flight are never forwarded after reset.

Optional Feature:
Macro SCOREBOARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and fwd_hits[31:0], both reset to 0.
  - stall_cycles increments on each cycle with stall = 1.
  - fwd_hits increments by the number of sources (0..2) with nonzero sel, counted only on non-stalled, non-flushed valid cycles.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset asserted, then `addi x5` issued, then `add x6,x5,x5` the next cycle -> fwd1_sel = fwd2_sel = 1, fwd data = stage_data slot0 (e.g. 32'h0000_0007), stall = 0.
2. `lw x7` then `add x8,x7,x0` (LOAD_LAT = 1) -> stall = 1 for exactly 1 cycle. Next cycle fwd1_sel = 2 with stage_data slot1 = 32'hDEAD_BEEF, stall = 0.
3. `addi x9` at slot2, `addi x9` at slot0, consumer reads x9 -> fwd1_sel = 1 (youngest), not 3.
4. Writer to x0 issued, consumer reads x0 -> slot not allocated, sel = 0, pending_cnt unchanged.
5. flush = 1 together with a load-use dependency -> stall = 0, slot[0] bubble, pending_cnt decreases by retirements only.
6. Three back-to-back writers, then reset asserted mid-stream -> pending_cnt = 0 and sel = 0 immediately. With SCOREBOARD_STATS_EN, stall_cycles = 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard/forwarding scoreboard signal bundle.
// master = ID stage (issues instructions), slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3
);
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_wen;
    logic                  issue_is_load;
    logic                  flush;
    logic [AW-1:0]         src1_addr;
    logic [AW-1:0]         src2_addr;
    logic [XLEN-1:0]       rf_rs1_data;
    logic [XLEN-1:0]       rf_rs2_data;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                  stall;
    logic [XLEN-1:0]       fwd_rs1_data;
    logic [XLEN-1:0]       fwd_rs2_data;
    logic [3:0]            fwd1_sel;
    logic [3:0]            fwd2_sel;
    logic [3:0]            pending_cnt;

    modport master (
        output issue_valid, issue_rd, issue_wen, issue_is_load, flush,
        output src1_addr, src2_addr, rf_rs1_data, rf_rs2_data, stage_data,
        input  stall, fwd_rs1_data, fwd_rs2_data, fwd1_sel, fwd2_sel, pending_cnt
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wen, issue_is_load, flush,
        input  src1_addr, src2_addr, rf_rs1_data, rf_rs2_data, stage_data,
        output stall, fwd_rs1_data, fwd_rs2_data, fwd1_sel, fwd2_sel, pending_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding scoreboard: shifting slot array of in-flight writes.
// Optional macro SCOREBOARD_STATS_EN adds saturating stall_cycles / fwd_hits counters.
module hazard_scoreboard #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         fwd_hits
`endif
);

    localparam int AVW = 4;

    typedef struct packed {
        logic            ready;
        logic [3:0]      sel;
        logic [XLEN-1:0] data;
    } look_t;

    logic [DEPTH-1:0]      slot_v;
    logic [AW-1:0]         slot_rd    [DEPTH];
    logic [AVW-1:0]        slot_avail [DEPTH];
    logic [DEPTH-1:0]      next_v;
    logic [3:0]            pending_cnt;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                  issue_valid;
    logic                  stall;
    logic                  insert;
    look_t                 look1;
    look_t                 look2;

    assign stage_data  = bus.stage_data;
    assign issue_valid = bus.issue_valid;

    function automatic logic [3:0] count_ones(input logic [DEPTH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < DEPTH; k++) n = n + 4'(v[k]);
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Youngest matching writer wins; a load that has not reached LOAD_LAT is not ready.
    function automatic look_t lookup(input logic [AW-1:0] addr, input logic [XLEN-1:0] rf,
                                     input logic valid, input logic in_reset);
        look_t r;
        logic  hit;
        r.ready = 1'b1;
        r.sel   = '0;
        r.data  = rf;
        hit     = 1'b0;
        if (valid && !in_reset && addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit && slot_v[k] && slot_rd[k] == addr) begin
                    hit = 1'b1;
                    if (AVW'(k) >= slot_avail[k]) begin
                        r.sel  = 4'(k + 1);
                        r.data = stage_data[k*XLEN +: XLEN];
                    end else begin
                        r.ready = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        look1  = lookup(bus.src1_addr, bus.rf_rs1_data, issue_valid, reset);
        look2  = lookup(bus.src2_addr, bus.rf_rs2_data, issue_valid, reset);
        stall  = (!look1.ready || !look2.ready) && !bus.flush;
        insert = issue_valid && bus.issue_wen && (bus.issue_rd != '0) && !stall && !bus.flush;
        next_v = {slot_v[DEPTH-2:0], insert};
    end

    assign bus.stall        = stall;
    assign bus.fwd1_sel     = look1.sel;
    assign bus.fwd2_sel     = look2.sel;
    assign bus.fwd_rs1_data = look1.data;
    assign bus.fwd_rs2_data = look2.data;
    assign bus.pending_cnt  = pending_cnt;

    // Slot shift: valid bits and count are reset, payload fields are not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v      <= '0;
            pending_cnt <= '0;
        end else begin
            slot_v      <= next_v;
            pending_cnt <= count_ones(next_v);
        end
    end

    always_ff @(posedge clk) begin
        slot_rd[0]    <= bus.issue_rd;
        slot_avail[0] <= bus.issue_is_load ? AVW'(LOAD_LAT) : '0;
        for (int k = 1; k < DEPTH; k++) begin
            slot_rd[k]    <= slot_rd[k-1];
            slot_avail[k] <= slot_avail[k-1];
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [1:0] hit_cnt;

    always_comb begin
        hit_cnt = '0;
        if (issue_valid && !stall && !bus.flush)
            hit_cnt = 2'(look1.sel != '0) + 2'(look2.sel != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            fwd_hits     <= '0;
        end else begin
            stall_cycles <= sat_add(stall_cycles, {1'b0, stall});
            fwd_hits     <= sat_add(fwd_hits, hit_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=1).
module tb_hazard_scoreboard;

    localparam logic [31:0] RF1 = 32'h1111_1111;
    localparam logic [31:0] RF2 = 32'h2222_2222;
    localparam logic [31:0] SD0 = 32'h0000_0007;
    localparam logic [31:0] SD1 = 32'hDEAD_BEEF;
    localparam logic [31:0] SD2 = 32'hCAFE_0002;

    typedef struct {
        string tag;
        int    stall;
        int    sel1;
        int    sel2;
        int    pend;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    int    n_chk  = 0;
    int    n_pass = 0;
    exp_t  exp_q[$];
    exp_t  cur;

    hazard_scoreboard_if #(.XLEN(32), .AW(5), .DEPTH(3)) bus ();

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] fwd_hits;
    hazard_scoreboard #(.XLEN(32), .AW(5), .DEPTH(3), .LOAD_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .stall_cycles(stall_cycles), .fwd_hits(fwd_hits));
`else
    hazard_scoreboard #(.XLEN(32), .AW(5), .DEPTH(3), .LOAD_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] exp_data(input int sel, input logic [31:0] rf);
        case (sel)
            1:       return SD0;
            2:       return SD1;
            3:       return SD2;
            default: return rf;
        endcase
    endfunction

    // Pops the oldest expectation and checks the combinational outputs (sel < 0 = don't care).
    task automatic check_comb();
        cur = exp_q.pop_front();
        chk({cur.tag, ".stall"}, 32'(bus.stall), 32'(cur.stall));
        if (cur.sel1 >= 0) begin
            chk({cur.tag, ".sel1"}, 32'(bus.fwd1_sel), 32'(cur.sel1));
            chk({cur.tag, ".d1"}, bus.fwd_rs1_data, exp_data(cur.sel1, RF1));
        end
        if (cur.sel2 >= 0) begin
            chk({cur.tag, ".sel2"}, 32'(bus.fwd2_sel), 32'(cur.sel2));
            chk({cur.tag, ".d2"}, bus.fwd_rs2_data, exp_data(cur.sel2, RF2));
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic w, input logic ld,
                         input logic f, input logic [4:0] a1, input logic [4:0] a2);
        bus.issue_valid   = v;
        bus.issue_rd      = rd;
        bus.issue_wen     = w;
        bus.issue_is_load = ld;
        bus.flush         = f;
        bus.src1_addr     = a1;
        bus.src2_addr     = a2;
    endtask

    // One ID cycle: outputs checked mid-cycle, pending_cnt checked after the edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rd, input logic w,
                        input logic ld, input logic f, input logic [4:0] a1, input logic [4:0] a2,
                        input int es, input int e1, input int e2, input int ep);
        drive(v, rd, w, ld, f, a1, a2);
        exp_q.push_back('{tag, es, e1, e2, ep});
        #3;
        check_comb();
        @(posedge clk);
        #1;
        chk({cur.tag, ".pend"}, 32'(bus.pending_cnt), 32'(cur.pend));
    endtask

    task automatic expect_now(input string tag, input int es, input int e1, input int e2, input int ep);
        exp_q.push_back('{tag, es, e1, e2, ep});
        check_comb();
        chk({cur.tag, ".pend"}, 32'(bus.pending_cnt), 32'(cur.pend));
    endtask

    initial begin
        reset = 1'b1;
        bus.rf_rs1_data = RF1;
        bus.rf_rs2_data = RF2;
        bus.stage_data  = {SD2, SD1, SD0};
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #2;
        drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
        #1;
        expect_now("in_reset", 0, 0, 0, 0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // EX forwarding
        step("addi_x5",   1, 5'd5,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 1);
        step("add_x6",    1, 5'd6,  1, 0, 0, 5'd5,  5'd5, 0, 1, 1, 2);
        // load-use: one stall, then MEM forward
        step("lw_x7",     1, 5'd7,  1, 1, 0, 5'd0,  5'd0, 0, 0, 0, 3);
        step("lu_stall",  1, 5'd8,  1, 0, 0, 5'd7,  5'd0, 1, -1, 0, 2);
        step("lu_fwd",    1, 5'd8,  1, 0, 0, 5'd7,  5'd0, 0, 2, 0, 2);
        // youngest writer wins
        step("x9_old",    1, 5'd9,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 2);
        step("nowrite",   1, 5'd0,  0, 0, 0, 5'd0,  5'd0, 0, 0, 0, 2);
        step("x9_new",    1, 5'd9,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 2);
        step("young",     1, 5'd10, 1, 0, 0, 5'd9,  5'd9, 0, 1, 1, 2);
        // x0 never allocated; WB-slot forward
        step("wr_x0",     1, 5'd0,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 2);
        step("rd_x0_wb",  1, 5'd0,  0, 0, 0, 5'd0,  5'd9, 0, 0, 3, 1);
        // flush beats load-use stall
        step("lw_x11",    1, 5'd11, 1, 1, 0, 5'd0,  5'd0, 0, 0, 0, 1);
        step("flush",     1, 5'd12, 1, 0, 1, 5'd11, 5'd0, 0, -1, 0, 1);
        step("idle",      0, 5'd0,  0, 0, 0, 5'd0,  5'd0, 0, 0, 0, 1);
        // back-to-back writers, then reset mid-stream
        step("wr_x1",     1, 5'd1,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 1);
        step("wr_x2",     1, 5'd2,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 2);
        step("wr_x3",     1, 5'd3,  1, 0, 0, 5'd0,  5'd0, 0, 0, 0, 3);
        drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3);
        #2;
        expect_now("pre_rst", 0, 3, 1, 3);
`ifdef SCOREBOARD_STATS_EN
        chk("stall_cycles", stall_cycles, 32'd1);
        chk("fwd_hits", fwd_hits, 32'd6);
`endif
        reset = 1'b1;
        #1;
        expect_now("mid_rst", 0, 0, 0, 0);
`ifdef SCOREBOARD_STATS_EN
        chk("stall_cycles_rst", stall_cycles, 32'd0);
        chk("fwd_hits_rst", fwd_hits, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst",  1, 5'd0,  0, 0, 0, 5'd3,  5'd1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
